// File: rtl/riscv_memory.sv
// ============================================================================
// Module  : riscv_memory
// Brief   : RV32I memory stage: E->M register, wait-state data bus, load/store
//           alignment. Optional macro RISCV_MEM_MISALIGN_CHK_EN adds a misalignment check.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_memory #(
  parameter int XLEN_P      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ctrl_reg_wr_enE,
  input  logic              i_ctrl_result_srcE,
  input  logic [1:0]        i_ctrl_mux_selE,
  input  logic              i_ctrl_mem_wr_enE,
  input  logic [3:0]        i_ctrl_mem_byte_selE,
  input  logic [2:0]        i_ctrl_funct3E,
  input  logic [4:0]        i_regfile_rd_addrE,
  input  logic [XLEN_P-1:0] i_alu_resultE,
  input  logic [XLEN_P-1:0] i_mem_writedataE,
  input  logic [XLEN_P-1:0] i_ExtImmE,
  input  logic [XLEN_P-1:0] i_PCPlus4E,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [XLEN_P-1:0] o_dmem_addr,
  output logic [3:0]        o_dmem_be,
  output logic [XLEN_P-1:0] o_dmem_wdata,
  input  logic              i_dmem_ack,
  input  logic [XLEN_P-1:0] i_dmem_rdata,
  output logic              o_stallM,
  output logic              o_ctrl_reg_wr_enM,
  output logic              o_ctrl_result_srcM,
  output logic [4:0]        o_regfile_rd_addrM,
  output logic [XLEN_P-1:0] o_writeback_dataM,
  output logic [XLEN_P-1:0] o_load_dataM,
`ifdef RISCV_MEM_MISALIGN_CHK_EN
  output logic              o_misalignedM,
`endif
  output logic              o_bus_errM
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_WAIT  = 2'd1;
  localparam logic [1:0] c_ABORT = 2'd2;

  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

  logic              r_regWrEnM;
  logic              r_resultSrcM;
  logic [1:0]        r_muxSelM;
  logic              r_memWrEnM;
  logic [3:0]        r_byteSelM;
  logic [2:0]        r_funct3M;
  logic [4:0]        r_rdAddrM;
  logic [XLEN_P-1:0] r_aluResultM;
  logic [XLEN_P-1:0] r_writeDataM;
  logic [XLEN_P-1:0] r_extImmM;
  logic [XLEN_P-1:0] r_pcPlus4M;

  logic [1:0]         r_state;
  logic [1:0]         w_stateNext;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cntNext;

  logic              w_misaligned;
  logic              w_memOp;
  logic              w_abort;
  logic              w_stall;
  logic              w_loadDone;
  logic [XLEN_P-1:0] w_lane;

  // M pipeline register; frozen while the bus access is outstanding
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_regWrEnM   <= 1'b0;
      r_resultSrcM <= 1'b0;
      r_muxSelM    <= 2'b00;
      r_memWrEnM   <= 1'b0;
      r_byteSelM   <= 4'b0000;
      r_funct3M    <= 3'b000;
      r_rdAddrM    <= 5'd0;
      r_aluResultM <= '0;
      r_writeDataM <= '0;
      r_extImmM    <= '0;
      r_pcPlus4M   <= '0;
    end else if (!w_stall) begin
      r_regWrEnM   <= i_ctrl_reg_wr_enE;
      r_resultSrcM <= i_ctrl_result_srcE;
      r_muxSelM    <= i_ctrl_mux_selE;
      r_memWrEnM   <= i_ctrl_mem_wr_enE;
      r_byteSelM   <= i_ctrl_mem_byte_selE;
      r_funct3M    <= i_ctrl_funct3E;
      r_rdAddrM    <= i_regfile_rd_addrE;
      r_aluResultM <= i_alu_resultE;
      r_writeDataM <= i_mem_writedataE;
      r_extImmM    <= i_ExtImmE;
      r_pcPlus4M   <= i_PCPlus4E;
    end
  end

`ifdef RISCV_MEM_MISALIGN_CHK_EN
  assign w_misaligned = (r_resultSrcM | r_memWrEnM) &
                        (((r_funct3M[1:0] == 2'b01) & r_aluResultM[0]) |
                         ((r_funct3M[1:0] == 2'b10) & (r_aluResultM[1:0] != 2'b00)));
  assign o_misalignedM = w_misaligned;
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_memOp    = (r_resultSrcM | r_memWrEnM) & ~w_misaligned;
  assign w_abort    = (r_state == c_ABORT);
  assign w_stall    = w_memOp & ~i_dmem_ack & ~w_abort;
  assign w_loadDone = r_resultSrcM & i_dmem_ack & ~w_abort & ~w_misaligned;
  assign w_lane     = i_dmem_rdata >> {r_aluResultM[1:0], 3'b000};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      c_IDLE: begin
        if (w_memOp && !i_dmem_ack) begin
          w_stateNext = c_WAIT;
          w_cntNext   = c_CNT_W'(1);
        end
      end
      c_WAIT: begin
        if (i_dmem_ack) begin
          w_stateNext = c_IDLE;
          w_cntNext   = '0;
        end else if (r_cnt >= c_CNT_LAST) begin
          w_stateNext = c_ABORT;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt + c_CNT_W'(1);
        end
      end
      default: begin
        w_stateNext = c_IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  always_comb begin
    o_dmem_req         = w_memOp & ~w_abort;
    o_dmem_we          = r_memWrEnM;
    o_dmem_addr        = {r_aluResultM[XLEN_P-1:2], 2'b00};
    o_dmem_be          = r_byteSelM << r_aluResultM[1:0];
    o_stallM           = w_stall;
    o_bus_errM         = w_abort;
    o_ctrl_reg_wr_enM  = r_regWrEnM & ~w_abort & ~w_misaligned;
    o_ctrl_result_srcM = r_resultSrcM;
    o_regfile_rd_addrM = r_rdAddrM;

    case (r_funct3M[1:0])
      2'b00:   o_dmem_wdata = {4{r_writeDataM[7:0]}};
      2'b01:   o_dmem_wdata = {2{r_writeDataM[15:0]}};
      default: o_dmem_wdata = r_writeDataM;
    endcase

    case (r_muxSelM)
      2'b01:   o_writeback_dataM = r_pcPlus4M;
      2'b10:   o_writeback_dataM = r_extImmM;
      default: o_writeback_dataM = r_aluResultM;
    endcase

    // Load data is driven only in the completion cycle so idle/reset reads 0
    o_load_dataM = '0;
    if (w_loadDone) begin
      case (r_funct3M)
        3'b000:  o_load_dataM = {{(XLEN_P-8){w_lane[7]}}, w_lane[7:0]};
        3'b001:  o_load_dataM = {{(XLEN_P-16){w_lane[15]}}, w_lane[15:0]};
        3'b010:  o_load_dataM = w_lane;
        3'b100:  o_load_dataM = {{(XLEN_P-8){1'b0}}, w_lane[7:0]};
        3'b101:  o_load_dataM = {{(XLEN_P-16){1'b0}}, w_lane[15:0]};
        default: o_load_dataM = '0;
      endcase
    end
  end

endmodule

`default_nettype wire
